// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// size-to-byte-count constants and alignment check.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_access_size_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_t;

  localparam logic [2:0] BYTES_BYTE = 3'd1;
  localparam logic [2:0] BYTES_HALF = 3'd2;
  localparam logic [2:0] BYTES_WORD = 3'd4;

  function automatic logic [2:0] size_bytes(input mem_access_size_t size);
    case (size)
      SIZE_BYTE: return BYTES_BYTE;
      SIZE_HALF: return BYTES_HALF;
      default:   return BYTES_WORD;
    endcase
  endfunction

  // Only the low two address bits matter for natural alignment.
  function automatic logic is_aligned(input logic [1:0] addr_lo, input mem_access_size_t size);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~addr_lo[0];
      default:   return (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Memory-side interface of the LSU. The LSU connects through the slave modport
// (it drives addresses/write data); the memory model uses the master modport.
// Reads are combinational, writes commit on the clock edge while wr_enable is high.
interface mem_if;
  import lsu_pkg::*;

  logic [31:0]      rd_addr;
  mem_access_size_t rd_size;
  logic [31:0]      rd_data;
  logic [31:0]      wr_addr;
  mem_access_size_t wr_size;
  logic [31:0]      wr_data;
  logic             wr_enable;

  modport slave (
    output rd_addr, rd_size, wr_addr, wr_size, wr_data, wr_enable,
    input  rd_data
  );

  modport master (
    input  rd_addr, rd_size, wr_addr, wr_size, wr_data, wr_enable,
    output rd_data
  );

endinterface

// File: rtl/lsu_data_align.sv
// Load data path: merges a byte beat into the partially assembled word when an
// access is split, then zero/sign-extends the result according to the size.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [31:0]      buf_i,
  input  logic [31:0]      rd_data_i,
  input  logic [1:0]       beat_i,
  input  logic             split_i,
  input  mem_access_size_t size_i,
  input  logic             signed_i,
  output logic [31:0]      merged_o,
  output logic [31:0]      ext_o
);

  // Split beats land in their little-endian byte lane; whole beats replace the word.
  always_comb begin
    merged_o = rd_data_i;
    if (split_i) begin
      merged_o = buf_i;
      merged_o[{beat_i, 3'b000} +: 8] = rd_data_i[7:0];
    end
  end

  // Extend the assembled value to 32 bits.
  always_comb begin
    ext_o = merged_o;
    case (size_i)
      SIZE_BYTE: ext_o = signed_i ? {{24{merged_o[7]}}, merged_o[7:0]}
                                  : {24'h0, merged_o[7:0]};
      SIZE_HALF: ext_o = signed_i ? {{16{merged_o[15]}}, merged_o[15:0]}
                                  : {16'h0, merged_o[15:0]};
      default:   ext_o = merged_o;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, performs one aligned beat or,
// with LSU_MISALIGNED_SPLIT_EN defined, splits misaligned HALF/WORD accesses into
// byte beats. Without the macro a misaligned access is rejected with resp_err_o.
module lsu
  import lsu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [31:0]      req_addr_i,
  input  mem_access_size_t req_size_i,
  input  logic             req_signed_i,
  input  logic [31:0]      req_wdata_i,
  output logic             resp_valid_o,
  output logic [31:0]      resp_rdata_o,
  output logic             resp_err_o,
  mem_if.slave             memif
);

  lsu_state_t       state_q;
  logic [1:0]       beat_q;
  logic [31:0]      addr_q;
  mem_access_size_t size_q;
  logic             we_q;
  logic             signed_q;
  logic [31:0]      wdata_q;
  logic [31:0]      buf_q;
  logic             resp_valid_q;
  logic [31:0]      resp_rdata_q;
  logic             resp_err_q;

  logic             aligned;
  logic             split;
  logic             err_access;
  logic [2:0]       nbeats;
  logic             last_beat;
  logic [31:0]      beat_addr;
  mem_access_size_t beat_size;
  logic [31:0]      buf_d;
  logic [31:0]      rdata_d;

  assign aligned = is_aligned(addr_q[1:0], size_q);

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign split      = ~aligned;
  assign err_access = 1'b0;
`else
  assign split      = 1'b0;
  assign err_access = ~aligned;
`endif

  assign nbeats    = split ? size_bytes(size_q) : 3'd1;
  assign last_beat = (({1'b0, beat_q} + 3'd1) == nbeats);
  assign beat_addr = addr_q + {30'h0, beat_q};
  assign beat_size = split ? SIZE_BYTE : size_q;

  assign req_ready_o  = (state_q == ST_IDLE) && rst_ni;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

  assign memif.rd_addr   = beat_addr;
  assign memif.rd_size   = beat_size;
  assign memif.wr_addr   = beat_addr;
  assign memif.wr_size   = beat_size;
  assign memif.wr_data   = split ? (wdata_q >> {beat_q, 3'b000}) : wdata_q;
  assign memif.wr_enable = (state_q == ST_ACCESS) && we_q && rst_ni && ~err_access;

  lsu_data_align u_align (
    .buf_i     (buf_q),
    .rd_data_i (memif.rd_data),
    .beat_i    (beat_q),
    .split_i   (split),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .merged_o  (buf_d),
    .ext_o     (rdata_d)
  );

  // Control FSM with registered response outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      beat_q       <= 2'd0;
      addr_q       <= 32'h0;
      size_q       <= SIZE_WORD;
      we_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            size_q  <= req_size_i;
            we_q    <= req_we_i;
            beat_q  <= 2'd0;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (err_access || last_beat) begin
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_access;
            resp_rdata_q <= (err_access || we_q) ? 32'h0 : rdata_d;
          end else begin
            beat_q <= beat_q + 2'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request data and load assembly buffer; these carry no reset.
  always_ff @(posedge clk_i) begin
    if (req_valid_i && req_ready_o) begin
      signed_q <= req_signed_i;
      wdata_q  <= req_wdata_i;
      buf_q    <= 32'h0;
    end else if (state_q == ST_ACCESS) begin
      buf_q <= buf_d;
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameters: none; all widths fixed at 32 bits.
REQ-002 clk_i  input  1  sole clock, all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 req_valid_i  input  1  core request present.
REQ-005 req_ready_o  output  1  lsu accepts a request; transfer occurs when req_valid_i && req_ready_o.
REQ-006 req_we_i  input  1  1 = store, 0 = load.
REQ-007 req_addr_i  input  32  byte address.
REQ-008 req_size_i  input  mem_access_size_t  BYTE/HALF/WORD.
REQ-009 req_signed_i  input  1  sign-extend load data (ignored for WORD and stores).
REQ-010 req_wdata_i  input  32  store data, right-aligned.
REQ-011 resp_valid_o  output  1  one-cycle pulse, access complete.
REQ-012 resp_rdata_o  output  32  extended load data, valid with resp_valid_o; 0 for stores.
REQ-013 resp_err_o  output  1  misaligned access rejected, valid with resp_valid_o.
REQ-014 memif  mem_if.slave  --  initiator end of the memory interface (rd_addr, rd_size, rd_data, wr_addr, wr_size, wr_data, wr_enable); memory read is combinational, writes commit on the clk_i edge while wr_enable is high.

Function
REQ-015 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on transfer, ACCESS->DONE after last beat, DONE->IDLE unconditionally.
REQ-016 req_ready_o = 1 only in IDLE with rst_ni high; the request is latched (addr, size, signed, we, wdata) on transfer.
REQ-017 Aligned access (addr mod size == 0): one beat in the cycle after transfer at the latched addr/size; resp_valid_o two cycles after transfer.
REQ-018 Each ACCESS beat: load captures memif.rd_data at the clock edge; store drives wr_enable=1, wr_addr, wr_size, wr_data for exactly that cycle.
REQ-019 wr_enable shall be (state==ACCESS) && latched we && rst_ni; never high in IDLE or DONE.
REQ-020 rd_addr/wr_addr and rd_size/wr_size driven from the current beat address/size in all states.
REQ-021 Load result: BYTE/HALF zero- or sign-extended per req_signed_i to 32 bits; WORD unchanged.
REQ-022 resp_rdata_o and resp_err_o held stable from DONE until the next DONE.
REQ-023 Beat address arithmetic is modulo 2^32 (0xFFFFFFFF + 1 = 0x00000000).
REQ-024 No request accepted in ACCESS or DONE; req_valid_i is ignored there (no queueing).

Reset
REQ-025 On a clock edge with rst_ni low: state=IDLE, beat counter 0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, latched addr 0, latched size WORD.
REQ-026 Reset during ACCESS aborts the operation: wr_enable low in the reset cycle, no response issued, already-committed bytes remain written.

Configuration
REQ-027 Macro LSU_MISALIGNED_SPLIT_EN defined: misaligned HALF/WORD split into 2/4 BYTE beats at addr, addr+1, ... little-endian, one per cycle; resp_valid_o at transfer+size_bytes+1; resp_err_o never set.
REQ-028 Macro undefined: misaligned access performs no memory beat (wr_enable stays 0), goes ACCESS->DONE in one cycle with resp_err_o=1, resp_rdata_o=0.

Structure
REQ-029 lsu_state_t enum and size-to-bytes helper constants belong in package definitions alongside mem_access_size_t.
REQ-030 One sub-module lsu_data_align: combinational byte-lane merge of split beats plus sign/zero extension.

Verification
REQ-031 Load WORD addr 0x100, mem=0xDEADBEEF -> resp_valid_o at transfer+2, rdata 0xDEADBEEF, err 0.
REQ-032 Load BYTE signed addr 0x103, mem byte 0x80 -> rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-033 Store HALF 0xA5A5 addr 0x202, split enabled -> exactly one wr_enable cycle, mem16[0x202]=0xA5A5.
REQ-034 Store WORD 0x11223344 addr 0x101, split enabled -> four byte writes 0x44,0x33,0x22,0x11 at 0x101..0x104, resp at transfer+5; split disabled -> no write, resp_err_o=1 at transfer+2.
REQ-035 Load WORD addr 0xFFFFFFFE split enabled -> beats at 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1, correct merge.
REQ-036 rst_ni low during second beat of split store -> wr_enable low that cycle, no resp_valid_o, req_ready_o=1 one cycle after rst_ni returns high.
